vga_scroll_sequencer: RTL and testbench
=======================================

# vga_scroll_sequencer

Frame-synchronous controller for the VGA pattern datapath. It owns the scroll offsets, scroll speeds and pattern mode that feed the pixel pattern logic, and advances them once per frame. It takes simple commands over a valid/ready handshake and applies them only at frame boundaries, so the picture never tears mid-frame. Everything runs in the pixel `clk` domain; the block detects the frame edge by sampling `vsync` and never clocks on `vsync`.

## Interface

Parameters:

- `OFFSET_W`, default 10: width of `offset_x` and `offset_y`.
- `FRAME_W`, default 8: width of `frame_cnt`.

Ports:

- `clk`  in  1: pixel clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `vsync`  in  1: active-low vertical sync from the sync generator, synchronous to `clk`.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_op`  in  3: opcode.
- `cmd_arg`  in  4: argument.
- `offset_x`  out  OFFSET_W: horizontal scroll offset.
- `offset_y`  out  OFFSET_W: vertical scroll offset.
- `mode`  out  2: pattern/palette select.
- `state`  out  2: scroll state; RUN=0, PAUSE=1, STEP=2.
- `frame_tick`  out  1: one-cycle pulse; new values are valid.
- `frame_cnt`  out  FRAME_W: frames since reset, wraps.

## Operation

- **Frame edge detection**
  - `vsync_q` is `vsync` registered, reset value 0.
  - A tick is the edge where `vsync==0` and `vsync_q==1`.
  - Because `vsync_q` resets to 0, a `vsync` held low through reset release does not produce a tick.
- **Command handshake**
  - There is a single pending slot, and `cmd_ready = !pending_valid`.
  - A command is accepted when `cmd_valid && cmd_ready` at a clock edge.
  - An accepted command is applied at the first tick strictly after its acceptance edge.
  - After that tick, `pending_valid` clears and `cmd_ready` returns high on the next cycle.
- **Opcodes**
  - 0 NOP: no effect.
  - 1 SET_SPEED_X: `speed_x = cmd_arg`, taken as signed 4-bit (-8..+7).
  - 2 SET_SPEED_Y: `speed_y = cmd_arg`, taken as signed 4-bit.
  - 3 PAUSE: state goes to PAUSE.
  - 4 RUN: state goes to RUN.
  - 5 STEP: state goes to STEP and `step_cnt = cmd_arg`; this yields `cmd_arg+1` advancing frames, then PAUSE.
  - 6 RESET_OFFSETS: both offsets go to 0 at this tick, overriding that tick's advance.
  - 7 SET_MODE: `mode = cmd_arg[1:0]`.
- **Ordering at a tick**
  - The advance decision uses the state and speeds held before the tick.
  - The pending command updates registers at the same edge, so its effect is visible from the next frame.
  - Exception: RESET_OFFSETS takes effect on its own tick.
- **Advance**
  - The block advances when the pre-tick state is RUN or STEP.
  - `offset_x += sign_extend(speed_x)` and `offset_y += sign_extend(speed_y)`, both modulo 2^OFFSET_W.
  - Negative speeds wrap below 0 to 2^OFFSET_W-1.
  - In PAUSE, the offsets hold.
- **STEP state**
  - At each tick in STEP, the block advances.
  - If `step_cnt==0`, state goes to PAUSE; otherwise `step_cnt` decrements.
  - A command applied at the same tick overrides the resulting state.
- **`frame_cnt`**: increments on every tick in every state and wraps to 0.
- **Reset values**
  - `offset_x=0`, `offset_y=0`, `speed_x=+1`, `speed_y=0`, `mode=0`, `state`=RUN, `step_cnt=0`, `frame_cnt=0`.
  - `frame_tick=0`, pending slot empty, `cmd_ready=1`.
  - With no commands, the default therefore scrolls one pixel per frame horizontally.
- **Reset mid-operation**: asserting `rst_n=0` drops any pending command and forces all reset values on the same edge.

## Timing

- **Tick edge**: `offset_x`, `offset_y`, `mode`, `state` and `frame_cnt` update at the tick edge.
- **`frame_tick`**
  - Registered; high for exactly the cycle following the tick edge, which is the first cycle showing the new values.
  - Pulses are at least one frame apart.
- **Command latency**: from acceptance to visible effect is at most one frame plus 1 cycle. A command accepted on a tick edge waits for the following tick.
- **Blocked command**: `cmd_valid` asserted while `cmd_ready=0` must be held by the requester. The block does not drop or overwrite the pending command.
- **Back-to-back commands**: at most one command is accepted per frame.
- **Stable outputs**: all outputs are registered and stable for the whole active video region.

## Test plan

- **Reset default**: reset, then 3 `vsync` falling edges.
  - `offset_x` = 1, 2, 3; `offset_y`=0; `frame_cnt`=3; `state`=RUN.
  - One `frame_tick` per frame, each exactly 1 cycle wide.
- **Negative speed wrap**: SET_SPEED_X arg=4'hE (-2), accepted mid-frame with `offset_x=1`.
  - At the next tick, `offset_x`=2 (old speed).
  - At the following ticks, `offset_x` = 0, then 1022.
- **STEP**: PAUSE applied, then STEP arg=2.
  - Offsets advance on exactly 3 ticks, then `state`=PAUSE and the offsets hold for 5 more frames.
  - `frame_cnt` keeps incrementing throughout.
- **Handshake**
  - Hold `cmd_valid` for two commands, SET_MODE 3 then SET_SPEED_Y 1.
  - `cmd_ready` is low after the first acceptance until 1 cycle after the next tick.
  - `mode`=3 after tick 1; `speed_y` takes effect and `offset_y` increments starting at tick 3.
- **Acceptance on a tick edge**: `cmd_valid` with RESET_OFFSETS on the exact tick edge.
  - Not applied at that tick; offsets become 0 at the next tick.
- **Reset mid-operation**
  - With a pending command and `state`=STEP, drive `rst_n` low for 1 cycle; all reset values appear, `cmd_ready`=1 and there is no spurious `frame_tick`.
  - With `vsync` low at reset release, no tick occurs until `vsync` rises and falls again.

Source files
------------

// File: rtl/vga_scroll_sequencer.sv
// Frame-synchronous scroll controller: holds offsets, speeds, mode and scroll state,
// applying one queued command and one advance per vsync falling edge.
module vga_scroll_sequencer #(
  parameter int unsigned OFFSET_W = 10,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [3:0]          cmd_arg,
  output logic [OFFSET_W-1:0] offset_x,
  output logic [OFFSET_W-1:0] offset_y,
  output logic [1:0]          mode,
  output logic [1:0]          state,
  output logic                frame_tick,
  output logic [FRAME_W-1:0]  frame_cnt
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StPause = 2'd1,
    StStep  = 2'd2
  } state_e;

  localparam logic [2:0] OpNop       = 3'd0;
  localparam logic [2:0] OpSpeedX    = 3'd1;
  localparam logic [2:0] OpSpeedY    = 3'd2;
  localparam logic [2:0] OpPause     = 3'd3;
  localparam logic [2:0] OpRun       = 3'd4;
  localparam logic [2:0] OpStep      = 3'd5;
  localparam logic [2:0] OpResetOffs = 3'd6;
  localparam logic [2:0] OpSetMode   = 3'd7;

  logic                vsync_q;
  logic                tick, accept;
  logic                pend_q, pend_d;
  logic [2:0]          pend_op_q, pend_op_d;
  logic [3:0]          pend_arg_q, pend_arg_d;
  logic [OFFSET_W-1:0] offset_x_q, offset_x_d, offset_y_q, offset_y_d;
  logic [3:0]          speed_x_q, speed_x_d, speed_y_q, speed_y_d;
  logic [1:0]          mode_q, mode_d;
  state_e              state_q, state_d;
  logic [3:0]          step_q, step_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                tick_q;

  // Frame edge: vsync just went low.
  assign tick   = ~vsync & vsync_q;
  assign accept = cmd_valid & ~pend_q;

  always_comb begin
    pend_d     = pend_q;
    pend_op_d  = pend_op_q;
    pend_arg_d = pend_arg_q;
    offset_x_d = offset_x_q;
    offset_y_d = offset_y_q;
    speed_x_d  = speed_x_q;
    speed_y_d  = speed_y_q;
    mode_d     = mode_q;
    state_d    = state_q;
    step_d     = step_q;
    frame_d    = frame_q;

    if (tick) begin
      frame_d = frame_q + FRAME_W'(1);
      // Advance uses the pre-tick state and speeds.
      if (state_q != StPause) begin
        offset_x_d = offset_x_q + {{(OFFSET_W-4){speed_x_q[3]}}, speed_x_q};
        offset_y_d = offset_y_q + {{(OFFSET_W-4){speed_y_q[3]}}, speed_y_q};
      end
      if (state_q == StStep) begin
        if (step_q == 4'd0) state_d = StPause;
        else                step_d  = step_q - 4'd1;
      end
      // Command applied at this edge overrides the STEP outcome.
      if (pend_q) begin
        pend_d = 1'b0;
        unique case (pend_op_q)
          OpNop:       ;
          OpSpeedX:    speed_x_d = pend_arg_q;
          OpSpeedY:    speed_y_d = pend_arg_q;
          OpPause:     state_d   = StPause;
          OpRun:       state_d   = StRun;
          OpStep: begin
            state_d = StStep;
            step_d  = pend_arg_q;
          end
          OpResetOffs: begin
            offset_x_d = '0;
            offset_y_d = '0;
          end
          OpSetMode:   mode_d    = pend_arg_q[1:0];
          default:     ;
        endcase
      end
    end

    // Only possible when the slot was empty, so never collides with the clear above.
    if (accept) begin
      pend_d     = 1'b1;
      pend_op_d  = cmd_op;
      pend_arg_d = cmd_arg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      tick_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_op_q  <= 3'd0;
      pend_arg_q <= 4'd0;
      offset_x_q <= '0;
      offset_y_q <= '0;
      speed_x_q  <= 4'd1;
      speed_y_q  <= 4'd0;
      mode_q     <= 2'd0;
      state_q    <= StRun;
      step_q     <= 4'd0;
      frame_q    <= '0;
    end else begin
      vsync_q    <= vsync;
      tick_q     <= tick;
      pend_q     <= pend_d;
      pend_op_q  <= pend_op_d;
      pend_arg_q <= pend_arg_d;
      offset_x_q <= offset_x_d;
      offset_y_q <= offset_y_d;
      speed_x_q  <= speed_x_d;
      speed_y_q  <= speed_y_d;
      mode_q     <= mode_d;
      state_q    <= state_d;
      step_q     <= step_d;
      frame_q    <= frame_d;
    end
  end

  assign cmd_ready  = ~pend_q;
  assign offset_x   = offset_x_q;
  assign offset_y   = offset_y_q;
  assign mode       = mode_q;
  assign state      = state_q;
  assign frame_tick = tick_q;
  assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_vga_scroll_sequencer.sv
// Bench for vga_scroll_sequencer: directed scenarios with literal expectations plus
// randomized frames/commands, all checked every cycle against a frame-level model.
module tb_vga_scroll_sequencer;

  localparam int OW = 10;
  localparam int FW = 8;
  localparam int OMOD = 1 << OW;
  localparam int FMOD = 1 << FW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [3:0]    cmd_arg;
  logic [OW-1:0] offset_x, offset_y;
  logic [1:0]    mode, state;
  logic          frame_tick;
  logic [FW-1:0] frame_cnt;

  vga_scroll_sequencer #(.OFFSET_W(OW), .FRAME_W(FW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .offset_x   (offset_x),
    .offset_y   (offset_y),
    .mode       (mode),
    .state      (state),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: state 0=RUN 1=PAUSE 2=STEP.
  int m_ox, m_oy, m_sx, m_sy, m_mode, m_state, m_step, m_frame;
  int m_pop, m_parg;
  bit m_vprev, m_pend, m_ftick;

  always @(posedge clk) begin
    bit tk, acc;
    if (!rst_n) begin
      m_ox = 0; m_oy = 0; m_sx = 1; m_sy = 0; m_mode = 0; m_state = 0; m_step = 0;
      m_frame = 0; m_vprev = 0; m_pend = 0; m_ftick = 0;
    end else begin
      tk  = m_vprev && !vsync;
      acc = cmd_valid && !m_pend;
      if (tk) begin
        m_frame = (m_frame + 1) % FMOD;
        if (m_state != 1) begin
          m_ox = ((m_ox + m_sx) % OMOD + OMOD) % OMOD;
          m_oy = ((m_oy + m_sy) % OMOD + OMOD) % OMOD;
        end
        if (m_state == 2) begin
          if (m_step == 0) m_state = 1;
          else m_step = m_step - 1;
        end
        if (m_pend) begin
          m_pend = 0;
          case (m_pop)
            1: m_sx = (m_parg >= 8) ? m_parg - 16 : m_parg;
            2: m_sy = (m_parg >= 8) ? m_parg - 16 : m_parg;
            3: m_state = 1;
            4: m_state = 0;
            5: begin m_state = 2; m_step = m_parg; end
            6: begin m_ox = 0; m_oy = 0; end
            7: m_mode = m_parg % 4;
            default: ;
          endcase
        end
      end
      if (acc) begin
        m_pend = 1;
        m_pop  = int'(cmd_op);
        m_parg = int'(cmd_arg);
      end
      m_ftick = tk;
      m_vprev = vsync;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("offset_x", int'(offset_x), m_ox);
      chk("offset_y", int'(offset_y), m_oy);
      chk("mode", int'(mode), m_mode);
      chk("state", int'(state), m_state);
      chk("frame_cnt", int'(frame_cnt), m_frame);
      chk("frame_tick", int'(frame_tick), int'(m_ftick));
      chk("cmd_ready", int'(cmd_ready), int'(!m_pend));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise vsync for hi cycles, then drop it; returns just after the tick edge.
  task automatic tick_frame(input int hi);
    vsync = 1'b1;
    repeat (hi) step();
    vsync = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic send(input int op, input int arg);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_arg   = 4'(arg);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 4'd0;
    repeat (2) step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    chk("rst ready", int'(cmd_ready), 1);
    chk("rst offset_x", int'(offset_x), 0);
    chk("rst state", int'(state), 0);

    // Default scroll: +1 per frame horizontally.
    for (int i = 1; i <= 3; i++) begin
      tick_frame(5);
      chk("default offset_x", int'(offset_x), i);
      chk("default tick", int'(frame_tick), 1);
      step();
      chk("default tick width", int'(frame_tick), 0);
      repeat (4) step();
    end
    chk("default frame_cnt", int'(frame_cnt), 3);
    chk("default offset_y", int'(offset_y), 0);

    // Negative speed wrap.
    do_reset();
    tick_frame(4);
    chk("wrap start", int'(offset_x), 1);
    repeat (3) step();
    send(1, 4'hE);
    chk("wrap pending ready", int'(cmd_ready), 0);
    tick_frame(4);
    chk("wrap old speed", int'(offset_x), 2);
    step();
    tick_frame(4);
    chk("wrap to zero", int'(offset_x), 0);
    step();
    tick_frame(4);
    chk("wrap below zero", int'(offset_x), 1022);

    // PAUSE then STEP 2: three advancing frames then hold.
    do_reset();
    send(3, 0);
    tick_frame(4);
    chk("pause x", int'(offset_x), 1);
    chk("pause state", int'(state), 1);
    send(5, 2);
    tick_frame(4);
    chk("step entry x", int'(offset_x), 1);
    chk("step entry state", int'(state), 2);
    for (int i = 0; i < 3; i++) begin
      tick_frame(4);
      chk("step x", int'(offset_x), 2 + i);
    end
    chk("step done state", int'(state), 1);
    for (int i = 0; i < 5; i++) begin
      tick_frame(3);
      chk("step hold x", int'(offset_x), 4);
    end
    chk("step frame_cnt", int'(frame_cnt), 10);

    // Handshake: held cmd_valid across two commands.
    do_reset();
    repeat (2) step();
    chk("low vsync no tick", int'(frame_cnt), 0);
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_arg = 4'd3;
    step();
    cmd_op = 3'd2; cmd_arg = 4'd1;
    chk("hs ready low", int'(cmd_ready), 0);
    tick_frame(4);
    chk("hs mode", int'(mode), 3);
    chk("hs ready back", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    chk("hs second accepted", int'(cmd_ready), 0);
    tick_frame(4);
    chk("hs y tick2", int'(offset_y), 0);
    tick_frame(4);
    chk("hs y tick3", int'(offset_y), 1);

    // Command accepted on the tick edge waits for the next tick.
    do_reset();
    tick_frame(4);
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd6; cmd_arg = 4'd0;
    step();
    cmd_valid = 1'b0;
    chk("edge cmd not applied", int'(offset_x), 2);
    chk("edge cmd pending", int'(cmd_ready), 0);
    repeat (2) step();
    tick_frame(3);
    chk("edge cmd applied", int'(offset_x), 0);

    // Reset mid-operation with a pending command and STEP state.
    do_reset();
    send(5, 5);
    tick_frame(4);
    chk("mid state step", int'(state), 2);
    send(7, 2);
    chk("mid pending", int'(cmd_ready), 0);
    do_reset();
    chk("mid ready", int'(cmd_ready), 1);
    chk("mid state", int'(state), 0);
    chk("mid frame_cnt", int'(frame_cnt), 0);
    chk("mid tick", int'(frame_tick), 0);
    repeat (5) step();
    chk("mid no spurious tick", int'(frame_cnt), 0);
    tick_frame(3);
    chk("mid mode dropped", int'(mode), 0);
    chk("mid x", int'(offset_x), 1);

    // Randomized frames and commands.
    for (int f = 0; f < 120; f++) begin
      int hi, lo;
      hi = $urandom_range(2, 12);
      lo = $urandom_range(2, 12);
      if ($urandom_range(0, 39) == 0) do_reset();
      vsync = 1'b1;
      for (int c = 0; c < hi + lo; c++) begin
        if (c == hi) vsync = 1'b0;
        cmd_valid = ($urandom_range(0, 3) == 0);
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_arg   = 4'($urandom_range(0, 15));
        step();
      end
    end
    cmd_valid = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
